fp_mult_normalizer: RTL
=======================

FP_MULT_NORMALIZER -- requirements
Module: fp_mult_normalizer

Interface
REQ-001 Parameter EXP_BIAS, default 7, exponent bias of the 12-bit float format (1 sign, 4 exponent, 7 fraction, hidden 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream operand/product set valid.
REQ-005 in_ready  output  1  block accepts the set this cycle when in_valid=1.
REQ-006 sign_a, sign_b  input  1 each  operand signs.
REQ-007 exp_a, exp_b  input  4 each  biased operand exponents.
REQ-008 prod  input  16  unsigned 8x8 mantissa product (hidden bits included, multiplier in unsigned mode).
REQ-009 zero_in  input  1  either operand is zero.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  12  packed {sign, exp[3:0], frac[6:0]}.
REQ-013 ovf, unf  output  1 each  overflow / underflow flags, qualified by out_valid.

Function
REQ-014 Two registered stages: S1 (sign, exponent sum, normalize), S2 (round, range check, pack); throughput one result per cycle.
REQ-015 Transfer in when in_valid && in_ready; out when out_valid && out_ready.
REQ-016 s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-017 Latency: an accepted set appears on result exactly 2 cycles later when out_ready is held high.
REQ-018 result, ovf, unf held stable while out_valid && !out_ready; no set dropped or duplicated.
REQ-019 S1 sign = sign_a ^ sign_b.
REQ-020 S1 exponent e = exp_a + exp_b - EXP_BIAS + norm, computed in 7-bit signed arithmetic, no wrap.
REQ-021 If prod[15]=1: norm=1, frac=prod[14:8], guard=prod[7], sticky=|prod[6:0].
REQ-022 Otherwise: norm=0, frac=prod[13:7], guard=prod[6], sticky=|prod[5:0].
REQ-023 A rounding carry out of frac (7'h7F+1) yields frac=0 and e+1, applied before the range check.
REQ-024 e >= 15: result={sign,4'hE,7'h7F}, ovf=1, unf=0.
REQ-025 e <= 0: result={sign,11'b0}, unf=1, ovf=0.
REQ-026 zero_in=1: result={sign,11'b0}, ovf=unf=0, overriding REQ-024/025.
REQ-027 Otherwise: result={sign,e[3:0],frac}, ovf=unf=0.

Reset
REQ-028 rst=1 immediately clears s1_valid and out_valid, forces result=0 and ovf=unf=0; in-flight sets are discarded.
REQ-029 After rst deasserts, in_ready=1 in the first cycle.

Configuration
REQ-030 Macro FP_ROUND_NEAREST_EN defined: round to nearest even; frac increments when guard && (sticky || frac[0]).
REQ-031 Macro FP_ROUND_NEAREST_EN undefined: truncate, guard and sticky ignored, REQ-023 unreachable; all other behaviour identical.

Verification
REQ-032 exp 7/7, prod 16'h4000, signs 0/0, out_ready=1 -> result 12'h380, flags 0, 2 cycles after acceptance.
REQ-033 exp 7/7, prod 16'h9000, signs 1/0 -> result 12'hC10 (norm=1, e=8).
REQ-034 exp 7/7, prod 16'h40C0 -> 12'h382 with FP_ROUND_NEAREST_EN, 12'h381 without; exp 7/7, prod 16'h7FFF with the macro -> 12'h400 (carry, e=8).
REQ-035 exp 14/14, prod 16'h4000 -> 12'h77F, ovf=1; exp 1/1, prod 16'h4000 -> 12'h000, unf=1; zero_in=1 with exp 14/14 -> 12'h000, flags 0.
REQ-036 Backpressure: out_ready=0, three back-to-back sets offered -> in_ready drops after two acceptances, result held constant; out_ready=1 -> three results in order, one per cycle.
REQ-037 rst pulsed with two sets in flight -> out_valid=0 and result=0 immediately; next accepted set -> correct result 2 cycles later.

Source files
------------

// File: rtl/fp_mult_normalizer_if.sv
// Handshake and data bundle for fp_mult_normalizer.
// master: upstream producer / downstream consumer side (drives operands and out_ready).
// slave : the normalizer itself.
interface fp_mult_normalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_a;
    logic        sign_b;
    logic [3:0]  exp_a;
    logic [3:0]  exp_b;
    logic [15:0] prod;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] result;
    logic        ovf;
    logic        unf;

    modport master (
        output in_valid, sign_a, sign_b, exp_a, exp_b, prod, zero_in, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, sign_a, sign_b, exp_a, exp_b, prod, zero_in, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fp_mult_normalizer.sv
// Two-stage normalizer for a 12-bit float multiply {sign, exp[3:0], frac[6:0]}.
// S1: sign, exponent sum, mantissa normalize. S2: round, range check, pack.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_mult_normalizer #(
    parameter int EXP_BIAS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_mult_normalizer_if.slave   bus
);

    logic               s2_adv;
    logic               s1_adv;

    logic               s1_valid_q;
    logic               s1_sign_q;
    logic signed [6:0]  s1_exp_q;
    logic [6:0]         s1_frac_q;
    logic               s1_zero_q;

    logic               s1_sign_d;
    logic signed [6:0]  s1_exp_d;
    logic [6:0]         s1_frac_d;
    logic               s1_norm;

`ifdef FP_ROUND_NEAREST_EN
    logic               s1_guard_q;
    logic               s1_sticky_q;
    logic               s1_guard_d;
    logic               s1_sticky_d;
`endif

    logic               out_valid_q;
    logic [11:0]        result_q;
    logic               ovf_q;
    logic               unf_q;

    logic [11:0]        result_d;
    logic               ovf_d;
    logic               unf_d;
    logic               round_inc;
    logic [7:0]         frac_sum;
    logic [6:0]         frac_r;
    logic signed [6:0]  exp_r;

    // Pipeline advances: output slot frees when consumed, S1 frees when it can move on.
    assign s2_adv        = !out_valid_q || bus.out_ready;
    assign s1_adv        = !s1_valid_q || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    // S1 datapath: product sign, normalize on prod[15], biased exponent sum (7-bit signed, no wrap).
    always_comb begin
        s1_sign_d = bus.sign_a ^ bus.sign_b;
        s1_norm   = bus.prod[15];
        if (s1_norm) begin
            s1_frac_d = bus.prod[14:8];
        end else begin
            s1_frac_d = bus.prod[13:7];
        end
`ifdef FP_ROUND_NEAREST_EN
        if (s1_norm) begin
            s1_guard_d  = bus.prod[7];
            s1_sticky_d = |bus.prod[6:0];
        end else begin
            s1_guard_d  = bus.prod[6];
            s1_sticky_d = |bus.prod[5:0];
        end
`endif
        s1_exp_d = 7'({3'b000, bus.exp_a}) + 7'({3'b000, bus.exp_b})
                 - 7'(EXP_BIAS) + 7'({6'b000000, s1_norm});
    end

    // S2 datapath: round (carry bumps exponent before range check), then saturate/flush/pack.
    always_comb begin
`ifdef FP_ROUND_NEAREST_EN
        round_inc = s1_guard_q && (s1_sticky_q || s1_frac_q[0]);
`else
        round_inc = 1'b0;
`endif
        frac_sum = {1'b0, s1_frac_q} + {7'b0000000, round_inc};
        frac_r   = frac_sum[7] ? 7'd0 : frac_sum[6:0];
        exp_r    = s1_exp_q + (frac_sum[7] ? 7'sd1 : 7'sd0);

        result_d = {s1_sign_q, exp_r[3:0], frac_r};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (s1_zero_q) begin
            result_d = {s1_sign_q, 11'b0};
        end else if (exp_r >= 7'sd15) begin
            result_d = {s1_sign_q, 4'hE, 7'h7F};
            ovf_d    = 1'b1;
        end else if (exp_r <= 7'sd0) begin
            result_d = {s1_sign_q, 11'b0};
            unf_d    = 1'b1;
        end
    end

    // S1 register: captures an accepted set whenever the stage is free to advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 7'sd0;
            s1_frac_q   <= 7'd0;
            s1_zero_q   <= 1'b0;
`ifdef FP_ROUND_NEAREST_EN
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q   <= s1_sign_d;
                s1_exp_q    <= s1_exp_d;
                s1_frac_q   <= s1_frac_d;
                s1_zero_q   <= bus.zero_in;
`ifdef FP_ROUND_NEAREST_EN
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
`endif
            end
        end
    end

    // S2 output register: holds result/flags while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= 12'h000;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
            end
        end
    end

endmodule
